// File: rtl/r200_pkg.sv
// Shared definitions for the r200 pipeline control slice: stage indices,
// forward-select encoding and the per-stage destination tag.
package r200_pkg;

   localparam int STG_IF = 0;
   localparam int STG_ID = 1;
   localparam int STG_EX = 2;

   localparam int FWD_RF = 0;

   // Tag rd field is sized for the widest supported register address; AW must not exceed it.
   localparam int TAG_AW = 8;

   typedef struct packed {
      logic              valid;
      logic [TAG_AW-1:0] rd;
      logic              regwr;
      logic              isload;
   } stage_tag_t;

   localparam stage_tag_t TAG_EMPTY = '{valid: 1'b0, rd: {TAG_AW{1'b0}}, regwr: 1'b0, isload: 1'b0};

   function automatic logic tag_match(input stage_tag_t t,
                                      input logic [TAG_AW-1:0] src,
                                      input logic use_src);
      return t.valid & t.regwr & (t.rd == src) & (src != {TAG_AW{1'b0}}) & use_src;
   endfunction

endpackage

// File: rtl/r200_fwd_sel.sv
// Youngest-match forwarding picker: scans in-flight stage tags for the
// lowest stage writing the requested source register.
module r200_fwd_sel
   import r200_pkg::*;
#(
   parameter int NSTAGE = 5,
   parameter int FW     = 3
) (
   input  stage_tag_t [NSTAGE-3:0] tags,
   input  logic [TAG_AW-1:0]       src,
   input  logic                    use_src,
   output logic [FW-1:0]           sel,
   output logic                    hit,
   output logic                    hit_load
);

   logic [NSTAGE-3:0] match_s;

   // Oldest stage first so the youngest match is the last one to overwrite the result.
   always_comb begin
      sel      = FW'(FWD_RF);
      hit      = 1'b0;
      hit_load = 1'b0;
      match_s  = {(NSTAGE-2){1'b0}};
      for (int i = NSTAGE - 3; i >= 0; i--) begin
         match_s[i] = tag_match(tags[i], src, use_src);
         sel        = match_s[i] ? FW'(i + STG_EX) : sel;
         hit_load   = match_s[i] ? tags[i].isload : hit_load;
         hit        = hit | match_s[i];
      end
   end

endmodule

// File: rtl/r200_pipe_ctrl.sv
// r200 pipeline control: stage tag tracking, operand forwarding, load-use
// bubbles, redirect flush and external freeze. Optional perf counters: R200_PERF_CNT_EN.
module r200_pipe_ctrl
   import r200_pkg::*;
#(
   parameter int NSTAGE       = 5,
   parameter int AW           = 5,
   parameter int FW           = 3,
   parameter int LD_FWD_STAGE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [AW-1:0]     id_rs1,
   input  logic [AW-1:0]     id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [AW-1:0]     id_rd,
   input  logic              id_regwr,
   input  logic              id_isload,
   input  logic              ex_redirect,
   input  logic              ext_stall,
   output logic              if_id_hold,
   output logic              ex_bubble,
   output logic              if_id_flush,
   output logic [FW-1:0]     rs1_fwd,
   output logic [FW-1:0]     rs2_fwd,
   output logic [NSTAGE-3:0] stg_valid,
   output logic              wb_wr_en
`ifdef R200_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cyc,
   output logic [31:0]       frz_cyc,
   output logic [31:0]       flush_cnt
`endif
);

   localparam int NT = NSTAGE - 2;

   stage_tag_t [NT-1:0] tags_q;
   stage_tag_t [NT-1:0] tags_d;
   stage_tag_t          id_tag_s;

   logic [TAG_AW-1:0] rs1_ext_s;
   logic [TAG_AW-1:0] rs2_ext_s;
   logic [FW-1:0]     rs1_sel_s;
   logic [FW-1:0]     rs2_sel_s;
   logic              rs1_hit_s;
   logic              rs2_hit_s;
   logic              rs1_ld_s;
   logic              rs2_ld_s;
   logic              rs1_lu_s;
   logic              rs2_lu_s;
   logic              lu_stall_s;
   logic              hold_s;
   logic              bubble_s;
   logic              flush_s;

   assign rs1_ext_s = TAG_AW'(id_rs1);
   assign rs2_ext_s = TAG_AW'(id_rs2);

   assign id_tag_s = '{valid: id_valid, rd: TAG_AW'(id_rd), regwr: id_regwr, isload: id_isload};

   r200_fwd_sel #(.NSTAGE(NSTAGE), .FW(FW)) u_fwd_rs1 (
      .tags     (tags_q),
      .src      (rs1_ext_s),
      .use_src  (id_use_rs1),
      .sel      (rs1_sel_s),
      .hit      (rs1_hit_s),
      .hit_load (rs1_ld_s)
   );

   r200_fwd_sel #(.NSTAGE(NSTAGE), .FW(FW)) u_fwd_rs2 (
      .tags     (tags_q),
      .src      (rs2_ext_s),
      .use_src  (id_use_rs2),
      .sel      (rs2_sel_s),
      .hit      (rs2_hit_s),
      .hit_load (rs2_ld_s)
   );

   // A load is only forwardable once it reaches LD_FWD_STAGE; earlier matches stall ID.
   assign rs1_lu_s   = id_valid & rs1_hit_s & rs1_ld_s & (int'(rs1_sel_s) < LD_FWD_STAGE);
   assign rs2_lu_s   = id_valid & rs2_hit_s & rs2_ld_s & (int'(rs2_sel_s) < LD_FWD_STAGE);
   assign lu_stall_s = rs1_lu_s | rs2_lu_s;

   // Next-state tags and pipeline steering, in priority freeze > redirect > load-use > advance.
   always_comb begin
      tags_d   = tags_q;
      hold_s   = 1'b0;
      bubble_s = 1'b0;
      flush_s  = 1'b0;
      if (ext_stall) begin
         hold_s = 1'b1;
      end else begin
         for (int s = 1; s < NT; s++) begin
            tags_d[s] = tags_q[s-1];
         end
         if (ex_redirect) begin
            flush_s   = 1'b1;
            bubble_s  = 1'b1;
            tags_d[0] = TAG_EMPTY;
         end else if (lu_stall_s) begin
            hold_s    = 1'b1;
            bubble_s  = 1'b1;
            tags_d[0] = TAG_EMPTY;
         end else begin
            tags_d[0] = id_tag_s;
         end
      end
   end

   // Stage tag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tags_q <= {NT{TAG_EMPTY}};
      end else begin
         tags_q <= tags_d;
      end
   end

   // Per-stage valid view for the datapath.
   always_comb begin
      stg_valid = {NT{1'b0}};
      for (int s = 0; s < NT; s++) begin
         stg_valid[s] = tags_q[s].valid;
      end
   end

   assign if_id_hold  = hold_s & ~rst;
   assign ex_bubble   = bubble_s & ~rst;
   assign if_id_flush = flush_s & ~rst;
   assign rs1_fwd     = rs1_lu_s ? FW'(FWD_RF) : rs1_sel_s;
   assign rs2_fwd     = rs2_lu_s ? FW'(FWD_RF) : rs2_sel_s;
   assign wb_wr_en    = tags_q[NT-1].valid & tags_q[NT-1].regwr &
                        (tags_q[NT-1].rd != {TAG_AW{1'b0}});

`ifdef R200_PERF_CNT_EN
   logic [31:0] stall_cyc_q;
   logic [31:0] stall_cyc_d;
   logic [31:0] frz_cyc_q;
   logic [31:0] frz_cyc_d;
   logic [31:0] flush_cnt_q;
   logic [31:0] flush_cnt_d;

   // Counters bump only on cycles where the event actually steers the pipe.
   always_comb begin
      stall_cyc_d = stall_cyc_q + {31'd0, lu_stall_s & ~ext_stall & ~ex_redirect};
      frz_cyc_d   = frz_cyc_q + {31'd0, ext_stall};
      flush_cnt_d = flush_cnt_q + {31'd0, ex_redirect & ~ext_stall};
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cyc_q <= 32'd0;
         frz_cyc_q   <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cyc_q <= stall_cyc_d;
         frz_cyc_q   <= frz_cyc_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cyc = stall_cyc_q;
   assign frz_cyc   = frz_cyc_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_r200_pipe_ctrl.sv
// Directed self-checking bench for r200_pipe_ctrl at default parameters
// (NSTAGE=5, LD_FWD_STAGE=4). Perf counter ports connected under R200_PERF_CNT_EN.
module tb_r200_pipe_ctrl;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic [4:0] id_rd;
   logic       id_regwr;
   logic       id_isload;
   logic       ex_redirect;
   logic       ext_stall;
   logic       if_id_hold;
   logic       ex_bubble;
   logic       if_id_flush;
   logic [2:0] rs1_fwd;
   logic [2:0] rs2_fwd;
   logic [2:0] stg_valid;
   logic       wb_wr_en;
`ifdef R200_PERF_CNT_EN
   logic [31:0] stall_cyc;
   logic [31:0] frz_cyc;
   logic [31:0] flush_cnt;
`endif

   int errs;
   int checks;

   r200_pipe_ctrl #(.NSTAGE(5), .AW(5), .FW(3), .LD_FWD_STAGE(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .id_rd       (id_rd),
      .id_regwr    (id_regwr),
      .id_isload   (id_isload),
      .ex_redirect (ex_redirect),
      .ext_stall   (ext_stall),
      .if_id_hold  (if_id_hold),
      .ex_bubble   (ex_bubble),
      .if_id_flush (if_id_flush),
      .rs1_fwd     (rs1_fwd),
      .rs2_fwd     (rs2_fwd),
      .stg_valid   (stg_valid),
      .wb_wr_en    (wb_wr_en)
`ifdef R200_PERF_CNT_EN
      ,
      .stall_cyc   (stall_cyc),
      .frz_cyc     (frz_cyc),
      .flush_cnt   (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic h, input logic b, input logic f);
      chk({tag, ".hold"},   32'(if_id_hold),  32'(h));
      chk({tag, ".bubble"}, 32'(ex_bubble),   32'(b));
      chk({tag, ".flush"},  32'(if_id_flush), 32'(f));
   endtask

   task automatic chk_fwd(input string tag, input logic [2:0] f1, input logic [2:0] f2);
      chk({tag, ".rs1_fwd"}, 32'(rs1_fwd), 32'(f1));
      chk({tag, ".rs2_fwd"}, 32'(rs2_fwd), 32'(f2));
   endtask

   task automatic chk_stg(input string tag, input logic [2:0] sv, input logic wb);
      chk({tag, ".stg_valid"}, 32'(stg_valid), 32'(sv));
      chk({tag, ".wb_wr_en"},  32'(wb_wr_en),  32'(wb));
   endtask

   task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic wr, input logic ld);
      id_valid   = v;
      id_rs1     = r1;
      id_use_rs1 = u1;
      id_rs2     = r2;
      id_use_rs2 = u2;
      id_rd      = rd;
      id_regwr   = wr;
      id_isload  = ld;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errs        = 0;
      checks      = 0;
      rst         = 1'b1;
      ex_redirect = 1'b0;
      ext_stall   = 1'b0;
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #3;
      chk_ctl("reset", 1'b0, 1'b0, 1'b0);
      chk_fwd("reset", 3'd0, 3'd0);
      chk_stg("reset", 3'b000, 1'b0);
`ifdef R200_PERF_CNT_EN
      chk("reset.stall_cyc", stall_cyc, 32'd0);
      chk("reset.frz_cyc",   frz_cyc,   32'd0);
      chk("reset.flush_cnt", flush_cnt, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // ALU chain: add x5; add x6,x5; consumer of x5 and x6 writing x0
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      #1;
      chk_ctl("alu0", 1'b0, 1'b0, 1'b0);
      chk_fwd("alu0", 3'd0, 3'd0);
      step();
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      #1;
      chk_fwd("alu1", 3'd2, 3'd0);
      chk_ctl("alu1", 1'b0, 1'b0, 1'b0);
      chk_stg("alu1", 3'b001, 1'b0);
      step();
      drv(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b1, 1'b0);
      #1;
      chk_fwd("alu2", 3'd3, 3'd2);
      chk_stg("alu2", 3'b011, 1'b0);
      step();
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      chk_stg("alu3", 3'b111, 1'b1);
      step();
      chk_stg("alu4", 3'b110, 1'b1);
      step();

      // Load-use: lw x7; add x8,x7 -> two bubbles, then forward from stage 4
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      #1;
      chk_stg("x0wb", 3'b100, 1'b0);
      chk_ctl("lw", 1'b0, 1'b0, 1'b0);
      step();
      drv(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      #1;
      chk_ctl("lu1", 1'b1, 1'b1, 1'b0);
      chk_fwd("lu1", 3'd0, 3'd0);
      chk_stg("lu1", 3'b001, 1'b0);
      step();
      chk_ctl("lu2", 1'b1, 1'b1, 1'b0);
      chk_fwd("lu2", 3'd0, 3'd0);
      chk_stg("lu2", 3'b010, 1'b0);
      step();
      chk_ctl("lu3", 1'b0, 1'b0, 1'b0);
      chk_fwd("lu3", 3'd4, 3'd0);
      chk_stg("lu3", 3'b100, 1'b1);
      step();

      // Redirect overriding a pending load-use
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      #1;
      chk_stg("lu4", 3'b001, 1'b0);
      chk_ctl("lu4", 1'b0, 1'b0, 1'b0);
      step();
      drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
      ex_redirect = 1'b1;
      #1;
      chk_ctl("redir", 1'b0, 1'b1, 1'b1);
      chk_stg("redir", 3'b011, 1'b0);
      step();
      ex_redirect = 1'b0;
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
      #1;
      chk_stg("redir_nx", 3'b110, 1'b1);
      chk_ctl("redir_nx", 1'b0, 1'b0, 1'b0);
      step();

      // Freeze for three cycles mid-chain; redirect during freeze is ignored
      drv(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
      ext_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ex_redirect = (k == 1);
         #1;
         chk_ctl("frz", 1'b1, 1'b0, 1'b0);
         chk_fwd("frz", 3'd2, 3'd0);
         chk_stg("frz", 3'b101, 1'b1);
         step();
      end
      ext_stall   = 1'b0;
      ex_redirect = 1'b0;
      #1;
      chk_ctl("resume", 1'b0, 1'b0, 1'b0);
      chk_fwd("resume", 3'd2, 3'd0);
      chk_stg("resume", 3'b101, 1'b1);
      step();
      drv(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      chk_fwd("resume2", 3'd3, 3'd0);
      chk_stg("resume2", 3'b011, 1'b0);
      step();

      // Multi-match on x3 (stages 2 and 4) plus x4 at stage 3
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      step();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
      step();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      step();
      drv(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd12, 1'b1, 1'b0);
      #1;
      chk_fwd("multi", 3'd2, 3'd3);
      chk_stg("multi", 3'b111, 1'b1);
      step();

      // Writer to x0 followed by a reader of x0
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      step();
      drv(1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
      #1;
      chk_fwd("x0rd", 3'd0, 3'd4);
      step();
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
      chk_stg("x0wb2", 3'b110, 1'b0);

      // Asynchronous reset in the middle of a load-use stall
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      step();
      drv(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      #1;
      chk_ctl("lu_pre", 1'b1, 1'b1, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk_ctl("arst", 1'b0, 1'b0, 1'b0);
      chk_fwd("arst", 3'd0, 3'd0);
      chk_stg("arst", 3'b000, 1'b0);
`ifdef R200_PERF_CNT_EN
      chk("arst.stall_cyc", stall_cyc, 32'd0);
      chk("arst.frz_cyc",   frz_cyc,   32'd0);
      chk("arst.flush_cnt", flush_cnt, 32'd0);
`endif
      #1;
      rst = 1'b0;
      step();
      chk_stg("post_rst", 3'b001, 1'b0);
      chk_ctl("post_rst", 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/r200_pipe_ctrl.md
Name: r200_pipe_ctrl

Overview:
- Parametrised pipeline control unit for the r200 core family. It replaces the fixed 5-stage hazard detector and PC controller with one block.
- Tracks a destination tag per in-flight stage (EX..WB) and produces forwarding selects for ID operands.
- Detects load-use hazards and inserts bubbles; squashes IF/ID on an EX-resolved redirect; freezes on external memory stall.
- Sits beside the datapath; the datapath's stage registers obey its hold/bubble/flush outputs.

Parameters:
- NSTAGE, 5, total pipeline stages (IF=0, ID=1, EX=2, ..., WB=NSTAGE-1); legal range 5..8.
- AW, 5, register address width.
- FW, 3, forward-select width; must satisfy 2**FW >= NSTAGE.
- LD_FWD_STAGE, 4, first stage index whose register holds load data that can be forwarded; legal range 3..NSTAGE-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  AW  ID source 1 address.
- id_rs2  in  AW  ID source 2 address.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  AW  ID destination.
- id_regwr  in  1  ID writes rd.
- id_isload  in  1  ID is a load.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- ext_stall  in  1  memory not ready; freeze the whole pipe.
- if_id_hold  out  1  IF PC and IF/ID register keep their value.
- ex_bubble  out  1  ID/EX register loads a NOP.
- if_id_flush  out  1  IF/ID register loads a NOP.
- rs1_fwd  out  FW  0 = regfile, k = value from stage k (2..NSTAGE-1).
- rs2_fwd  out  FW  same encoding as rs1_fwd, for source 2.
- stg_valid  out  NSTAGE-2  valid bits for stages EX..WB (bit 0 = EX).
- wb_wr_en  out  1  qualified regfile write: valid & regwr & rd!=0 at WB.

Behaviour:
- Tag per stage s in 2..NSTAGE-1: {valid, rd, regwr, isload}. Held in flops; reset clears all valid bits. Outputs are combinational from tags and inputs; with all valid bits clear they read 0.
- Priority order: rst > ext_stall > ex_redirect > load-use stall > advance.
- Advance: tag[s] <= tag[s-1] for s >= 3. EX tag <= {id_valid, id_rd, id_regwr, id_isload}.
- ext_stall=1: all tags hold, if_id_hold=1, ex_bubble=0, if_id_flush=0. Forward selects stay valid. ex_redirect is ignored; its producer holds it until ext_stall drops.
- ex_redirect=1 (no ext_stall):
  - if_id_flush=1 and ex_bubble=1; the EX tag loads invalid.
  - The EX instruction advances normally.
  - if_id_hold=0.
  - Any load-use stall in the same cycle is overridden.
- Match on stage s: valid & regwr & rd==src & src!=0 & use_src.
- Forward select = youngest matching stage (lowest s). If no match, select 0.
- Load-use stall: the youngest match is a load with s < LD_FWD_STAGE, and id_valid=1. Response:
  - if_id_hold=1, ex_bubble=1.
  - Tags advance with EX loaded invalid.
  - The forward select for that operand reads 0 and must be ignored.
  - Stall repeats each cycle until the load reaches LD_FWD_STAGE. Stall length = LD_FWD_STAGE-2 cycles for a back-to-back dependency.
- Stage NSTAGE-1 (WB) is included in forwarding, so regfile write-before-read is not required.
- Writes to x0 never produce a match and never assert wb_wr_en.
- Reset mid-stall or mid-flush: all valid bits clear immediately; the first cycle after reset is a normal advance.

Optional Feature:
- R200_PERF_CNT_EN defined adds three outputs:
  - stall_cyc out 32: load-use stall cycles.
  - frz_cyc out 32: ext_stall cycles.
  - flush_cnt out 32: redirects.
- Counters wrap at 2**32, reset to 0, and do not count while rst is asserted.
- Without the macro the ports and flops are absent; behaviour is otherwise identical.

Decomposition:
- Shared package r200_pkg: stage index constants (STG_IF, STG_ID, STG_EX), the FWD_RF=0 encoding, and the stage tag struct {valid, rd, regwr, isload}.
- One natural sub-module: r200_fwd_sel. It is a combinational youngest-match priority picker, instantiated twice (rs1, rs2), and outputs select plus match-is-load.

Test Plan:
- ALU chain, NSTAGE=5: add x5 then add x6,x5 -> rs1_fwd=2, no stall. One cycle later a consumer of x5 gets rs1_fwd=3.
- Load-use, LD_FWD_STAGE=4: lw x7 then add x8,x7 -> if_id_hold=1 and ex_bubble=1 for 2 cycles, then rs1_fwd=4 with no hold.
- Redirect: ex_redirect=1 with a load-use pending in ID -> if_id_flush=1, ex_bubble=1, if_id_hold=0. Next cycle EX is invalid.
- ext_stall for 3 cycles mid-chain -> stg_valid and forward selects unchanged, if_id_hold=1 throughout; resumes exactly where it stopped.
- x0 and multi-match: writers to x3 at stages 2 and 4, reader of x3 -> rs1_fwd=2. A writer to x0 with a reader of x0 -> select 0, wb_wr_en=0.
- Async rst asserted mid-stall -> stg_valid=0 and all outputs 0 before the next clk edge. With R200_PERF_CNT_EN, counters read 0.
